pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/bubble controller for the 5-stage pipeline. Collects stall requests (IF bus wait, ID load-use hazard, EXE multi-cycle divide, MEM bus wait) and exception flush. Drives per-stage hold and bubble controls for the pipeline registers (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB). Sequences the iterative divider through a small FSM.

Parameters:
DIV_CNT_W, 6, width of divide-cycle counter (div_cycles output)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
if_stall_req  in  1  instruction bus not ready
mem_stall_req  in  1  data bus not ready
exc_flush  in  1  exception/eret flush, one-cycle pulse
id_rs  in  5  ID source reg 1 index
id_rt  in  5  ID source reg 2 index
id_rs_re  in  1  ID reads rs
id_rt_re  in  1  ID reads rt
exe_wd  in  5  EXE destination reg
exe_wreg  in  1  EXE writes a register
exe_is_load  in  1  EXE holds a load
exe_div_op  in  1  EXE holds DIV/DIVU
div_ready  in  1  divider result valid
stall  out  6  hold bits: [0]PC [1]IF/ID [2]ID/EXE [3]EXE/MEM [4]MEM/WB [5]WB
bubble  out  6  clear-to-NOP bits, same indexing
div_start  out  1  one-cycle divider launch
div_cancel  out  1  one-cycle divider abort
div_busy  out  1  FSM not IDLE
div_cycles  out  DIV_CNT_W  cycles spent in current/last divide, saturating
stall_cycles  out  32  perf counter (see Optional Feature)
flush_count  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (rst==0 at posedge): FSM->IDLE, div_cycles=0, counters=0. While rst==0 all outputs forced 0 combinationally.
- stall/bubble are combinational from inputs + FSM state; priority high->low:
  1 exc_flush: stall=000000, bubble=011110 (IF/ID..MEM/WB cleared).
  2 mem_stall_req: stall=011111, bubble=100000.
  3 divide stall (FSM IDLE with exe_div_op, or FSM RUN): stall=001111, bubble=010000.
  4 load-use: exe_is_load & exe_wreg & exe_wd!=0 & ((id_rs_re & id_rs==exe_wd) | (id_rt_re & id_rt==exe_wd)): stall=000111, bubble=001000.
  5 if_stall_req: stall=000011, bubble=000100.
  6 none: all 0.
- Divide FSM states IDLE, RUN, DONE:
  IDLE: exe_div_op & !exc_flush & !mem_stall_req -> div_start=1, div_cycles<=1, ->RUN.
  RUN: div_cycles increments (saturates at all-ones). exc_flush -> div_cancel=1, ->IDLE. div_ready -> DONE (div stall released same cycle; result registered by EXE/MEM). Else stay.
  DONE: exe_div_op ignored (no relaunch of same instr). mem_stall_req -> stay DONE; else ->IDLE. exc_flush -> IDLE, no cancel.
- div_ready outside RUN ignored. div_start and div_cancel never both 1.
- Back-to-back divides: second div enters EXE after DONE; IDLE launches it next cycle; minimum 1 idle cycle between launches.
- mem_stall_req during RUN: FSM keeps counting/advancing; only stall pattern changes.
- div_busy = (state != IDLE).

Optional Feature:
PIPE_PERF_EN defined: stall_cycles increments every cycle with stall[0]==1 and rst==1; flush_count increments per cycle with exc_flush==1; both wrap at 2^32. Undefined: both outputs tied to 0, no counter flops.

Test Plan:
- Load-use: exe_is_load=1, exe_wreg=1, exe_wd=5, id_rs=5, id_rs_re=1 -> stall=000111, bubble=001000 one cycle; same with exe_wd=0 -> stall=0.
- Divide: exe_div_op=1 in IDLE -> div_start=1, stall=001111; div_ready on 4th RUN cycle -> DONE, stall=0, div_cycles=4, then IDLE with no second div_start.
- Flush mid-divide: exc_flush in RUN -> div_cancel=1, bubble=011110, stall=0, state IDLE next cycle.
- Priority: mem_stall_req=1 with load-use and if_stall_req active -> stall=011111, bubble=100000; mem_stall in DONE holds DONE until released.
- Reset mid-RUN: rst=0 -> next cycle div_busy=0, div_cycles=0, all outputs 0 during reset.
- PIPE_PERF_EN: 3 load-use cycles + 2 flushes -> stall_cycles=3, flush_count=2; without macro both read 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: bundle between the pipeline datapath and the stall controller.
// Signals:
//   requests  : if_stall_req, mem_stall_req, exc_flush
//   hazard    : id_rs, id_rt, id_rs_re, id_rt_re, exe_wd, exe_wreg, exe_is_load
//   divider   : exe_div_op, div_ready (in); div_start, div_cancel, div_busy, div_cycles (out)
//   controls  : stall[5:0], bubble[5:0] ([0]PC [1]IF/ID [2]ID/EXE [3]EXE/MEM [4]MEM/WB [5]WB)
//   perf      : stall_cycles, flush_count
// Modports: master = pipeline side, slave = controller side.
interface pipe_stall_ctrl_if #(parameter int DIV_CNT_W = 6);
    logic                 if_stall_req;
    logic                 mem_stall_req;
    logic                 exc_flush;
    logic [4:0]           id_rs;
    logic [4:0]           id_rt;
    logic                 id_rs_re;
    logic                 id_rt_re;
    logic [4:0]           exe_wd;
    logic                 exe_wreg;
    logic                 exe_is_load;
    logic                 exe_div_op;
    logic                 div_ready;
    logic [5:0]           stall;
    logic [5:0]           bubble;
    logic                 div_start;
    logic                 div_cancel;
    logic                 div_busy;
    logic [DIV_CNT_W-1:0] div_cycles;
    logic [31:0]          stall_cycles;
    logic [31:0]          flush_count;

    modport master (
        output if_stall_req, mem_stall_req, exc_flush, id_rs, id_rt, id_rs_re, id_rt_re,
               exe_wd, exe_wreg, exe_is_load, exe_div_op, div_ready,
        input  stall, bubble, div_start, div_cancel, div_busy, div_cycles,
               stall_cycles, flush_count
    );

    modport slave (
        input  if_stall_req, mem_stall_req, exc_flush, id_rs, id_rt, id_rs_re, id_rt_re,
               exe_wd, exe_wreg, exe_is_load, exe_div_op, div_ready,
        output stall, bubble, div_start, div_cancel, div_busy, div_cycles,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/bubble controller and divider sequencer for the 5-stage pipeline.
// Ports:
//   clk : clock
//   rst : synchronous reset, active-low; all outputs read 0 while asserted
//   bus : pipe_stall_ctrl_if.slave (stall requests, hazard info, divider handshake,
//         per-stage stall/bubble controls, perf counters)
// Optional: define PIPE_PERF_EN to build the stall_cycles / flush_count counters;
//           otherwise both read 0 and no counter flops exist.
module pipe_stall_ctrl #(
    parameter int DIV_CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [DIV_CNT_W-1:0] cnt, cnt_nx;
    logic                 start, cancel, load_use, div_stall;
    logic [5:0]           stall_c, bubble_c;

    assign load_use = bus.exe_is_load && bus.exe_wreg && bus.exe_wd != 5'd0 &&
                      ((bus.id_rs_re && bus.id_rs == bus.exe_wd) ||
                       (bus.id_rt_re && bus.id_rt == bus.exe_wd));

    // A divide in RUN releases its stall in the same cycle div_ready arrives,
    // so EXE/MEM captures the result on that edge.
    assign div_stall = (state == IDLE && bus.exe_div_op) || (state == RUN && !bus.div_ready);

    assign {stall_c, bubble_c} =
        bus.exc_flush     ? {6'b000000, 6'b011110} :
        bus.mem_stall_req ? {6'b011111, 6'b100000} :
        div_stall         ? {6'b001111, 6'b010000} :
        load_use          ? {6'b000111, 6'b001000} :
        bus.if_stall_req  ? {6'b000011, 6'b000100} :
                            {6'b000000, 6'b000000};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // div_cycles counts RUN cycles only; the exit cycle does not add one,
    // so a result on the Nth RUN cycle leaves div_cycles == N.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        start    = 1'b0;
        cancel   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.exe_div_op && !bus.exc_flush && !bus.mem_stall_req) begin
                    start    = 1'b1;
                    cnt_nx   = DIV_CNT_W'(1);
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (bus.exc_flush) begin
                    cancel   = 1'b1;
                    state_nx = IDLE;
                end else if (bus.div_ready) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = &cnt ? cnt : cnt + DIV_CNT_W'(1);
                end
            end
            DONE: state_nx = (bus.mem_stall_req && !bus.exc_flush) ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.stall      = rst ? stall_c : 6'b0;
    assign bus.bubble     = rst ? bubble_c : 6'b0;
    assign bus.div_start  = rst && start;
    assign bus.div_cancel = rst && cancel;
    assign bus.div_busy   = rst && state != IDLE;
    assign bus.div_cycles = rst ? cnt : '0;

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + {31'b0, stall_c[0]};
            flush_cnt <= flush_cnt + {31'b0, bus.exc_flush};
        end
    end

    assign bus.stall_cycles = rst ? stall_cnt : 32'b0;
    assign bus.flush_count  = rst ? flush_cnt : 32'b0;
`else
    assign bus.stall_cycles = 32'b0;
    assign bus.flush_count  = 32'b0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed vector table plus multi-cycle sequences for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    pipe_stall_ctrl_if #(.DIV_CNT_W(6)) bus();
    pipe_stall_ctrl #(.DIV_CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       ifs, mems, fl;
        logic [4:0] rs, rt;
        logic       rsre, rtre;
        logic [4:0] wd;
        logic       wreg, ld, dv;
        logic [5:0] st, bu;
        logic       ds;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        bus.if_stall_req  = 1'b0;
        bus.mem_stall_req = 1'b0;
        bus.exc_flush     = 1'b0;
        bus.id_rs         = 5'd0;
        bus.id_rt         = 5'd0;
        bus.id_rs_re      = 1'b0;
        bus.id_rt_re      = 1'b0;
        bus.exe_wd        = 5'd0;
        bus.exe_wreg      = 1'b0;
        bus.exe_is_load   = 1'b0;
        bus.exe_div_op    = 1'b0;
        bus.div_ready     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        bus.exe_is_load = 1'b1;
        bus.exe_wreg    = 1'b1;
        bus.exe_wd      = 5'd5;
        bus.id_rs       = 5'd5;
        bus.id_rs_re    = 1'b1;
    endtask

    initial begin
        //           ifs  mem  fl   rs     rt     rsre rtre wd     wreg ld   dv    stall      bubble     ds
        vecs[0]  = '{1'b0,1'b0,1'b0,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0, 6'b000000, 6'b000000, 1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b1,1'b1,1'b0, 6'b000111, 6'b001000, 1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,5'd0, 1'b1,1'b1,1'b0, 6'b000000, 6'b000000, 1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,5'd3, 5'd9, 1'b1,1'b1,5'd9, 1'b1,1'b1,1'b0, 6'b000111, 6'b001000, 1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,5'd5, 5'd0, 1'b0,1'b0,5'd5, 1'b1,1'b1,1'b0, 6'b000000, 6'b000000, 1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b0,1'b1,1'b0, 6'b000000, 6'b000000, 1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b1,1'b0,1'b0, 6'b000000, 6'b000000, 1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0, 6'b000011, 6'b000100, 1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b1,1'b1,1'b0, 6'b011111, 6'b100000, 1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b1,5'd5, 5'd0, 1'b1,1'b0,5'd5, 1'b1,1'b1,1'b0, 6'b000000, 6'b011110, 1'b0};
        vecs[10] = '{1'b0,1'b1,1'b0,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b0,1'b1, 6'b011111, 6'b100000, 1'b0};
        vecs[11] = '{1'b0,1'b0,1'b1,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b0,1'b1, 6'b000000, 6'b011110, 1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,5'd7, 5'd0, 1'b1,1'b0,5'd7, 1'b1,1'b1,1'b0, 6'b000111, 6'b001000, 1'b0};

        clr();
        bus.if_stall_req = 1'b1;
        step();
        step();
        chk("reset stall", bus.stall, 6'b0);
        chk("reset bubble", bus.bubble, 6'b0);
        chk("reset busy", bus.div_busy, 1'b0);
        rst = 1'b1;
        clr();
        #1;

        for (int i = 0; i < 13; i++) begin
            bus.if_stall_req  = vecs[i].ifs;
            bus.mem_stall_req = vecs[i].mems;
            bus.exc_flush     = vecs[i].fl;
            bus.id_rs         = vecs[i].rs;
            bus.id_rt         = vecs[i].rt;
            bus.id_rs_re      = vecs[i].rsre;
            bus.id_rt_re      = vecs[i].rtre;
            bus.exe_wd        = vecs[i].wd;
            bus.exe_wreg      = vecs[i].wreg;
            bus.exe_is_load   = vecs[i].ld;
            bus.exe_div_op    = vecs[i].dv;
            #1;
            chk($sformatf("vec%0d stall", i), bus.stall, vecs[i].st);
            chk($sformatf("vec%0d bubble", i), bus.bubble, vecs[i].bu);
            chk($sformatf("vec%0d div_start", i), bus.div_start, vecs[i].ds);
            step();
        end
        clr();
        #1;
        chk("idle after table", bus.div_busy, 1'b0);

        // divide with result on the 4th RUN cycle
        bus.exe_div_op = 1'b1;
        bus.if_stall_req = 1'b1;
        #1;
        chk("div launch start", bus.div_start, 1'b1);
        chk("div launch stall", bus.stall, 6'b001111);
        chk("div launch bubble", bus.bubble, 6'b010000);
        step();
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("run%0d cycles", k), bus.div_cycles, k);
            chk($sformatf("run%0d stall", k), bus.stall, 6'b001111);
            chk($sformatf("run%0d start", k), bus.div_start, 1'b0);
            chk($sformatf("run%0d busy", k), bus.div_busy, 1'b1);
            step();
        end
        bus.if_stall_req = 1'b0;
        bus.div_ready = 1'b1;
        #1;
        chk("ready stall", bus.stall, 6'b0);
        chk("ready cycles", bus.div_cycles, 6'd4);
        step();
        bus.div_ready = 1'b0;
        #1;
        chk("done busy", bus.div_busy, 1'b1);
        chk("done start", bus.div_start, 1'b0);
        chk("done stall", bus.stall, 6'b0);
        chk("done cycles", bus.div_cycles, 6'd4);
        step();
        bus.exe_div_op = 1'b0;
        #1;
        chk("post div busy", bus.div_busy, 1'b0);
        chk("post div start", bus.div_start, 1'b0);
        chk("post div cycles", bus.div_cycles, 6'd4);

        // long divide saturates, then flush cancels it
        bus.exe_div_op = 1'b1;
        #1;
        step();
        for (int k = 0; k < 70; k++) step();
        chk("sat cycles", bus.div_cycles, 6'd63);
        chk("sat busy", bus.div_busy, 1'b1);
        bus.exc_flush = 1'b1;
        #1;
        chk("flush cancel", bus.div_cancel, 1'b1);
        chk("flush start", bus.div_start, 1'b0);
        chk("flush stall", bus.stall, 6'b0);
        chk("flush bubble", bus.bubble, 6'b011110);
        step();
        bus.exc_flush = 1'b0;
        bus.exe_div_op = 1'b0;
        #1;
        chk("flush idle busy", bus.div_busy, 1'b0);
        chk("flush idle cancel", bus.div_cancel, 1'b0);

        // mem stall during RUN keeps counting; mem stall in DONE holds DONE
        bus.exe_div_op = 1'b1;
        #1;
        step();
        bus.mem_stall_req = 1'b1;
        #1;
        chk("run mem stall", bus.stall, 6'b011111);
        step();
        chk("run mem cycles", bus.div_cycles, 6'd2);
        bus.mem_stall_req = 1'b0;
        bus.div_ready = 1'b1;
        #1;
        step();
        bus.div_ready = 1'b0;
        bus.mem_stall_req = 1'b1;
        #1;
        chk("done mem stall", bus.stall, 6'b011111);
        chk("done mem bubble", bus.bubble, 6'b100000);
        step();
        chk("done held busy", bus.div_busy, 1'b1);
        chk("done held start", bus.div_start, 1'b0);
        bus.mem_stall_req = 1'b0;
        bus.exe_div_op = 1'b0;
        #1;
        step();
        chk("done release busy", bus.div_busy, 1'b0);

        // reset mid-RUN
        bus.exe_div_op = 1'b1;
        #1;
        step();
        step();
        chk("pre reset busy", bus.div_busy, 1'b1);
        rst = 1'b0;
        bus.if_stall_req = 1'b1;
        #1;
        chk("in reset stall", bus.stall, 6'b0);
        chk("in reset bubble", bus.bubble, 6'b0);
        chk("in reset busy", bus.div_busy, 1'b0);
        chk("in reset cycles", bus.div_cycles, 6'd0);
        chk("in reset start", bus.div_start, 1'b0);
        step();
        rst = 1'b1;
        clr();
        #1;
        chk("after reset busy", bus.div_busy, 1'b0);
        chk("after reset cycles", bus.div_cycles, 6'd0);

        // perf counters: 3 load-use cycles, 2 flush cycles
        set_load_use();
        #1;
        for (int k = 0; k < 3; k++) step();
        clr();
        bus.exc_flush = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) step();
        clr();
        #1;
`ifdef PIPE_PERF_EN
        chk("stall_cycles", bus.stall_cycles, 32'd3);
        chk("flush_count", bus.flush_count, 32'd2);
`else
        chk("stall_cycles", bus.stall_cycles, 32'd0);
        chk("flush_count", bus.flush_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
